// File: rtl/compound_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a single CompoundType consumer.
// Each forwarded transaction is tagged with its source, and grants are counted per requester.
package testbasic18_types;
   typedef enum logic {read = 1'b0, write = 1'b1} mode_t;

   typedef struct packed {
      mode_t              mode;
      logic signed [31:0] x;
      logic               y;
   } CompoundType;
endpackage

// Handshake: a transfer happens on a rising edge where a port's sync and notify are both high.
// notify is the arbiter's side of the handshake and sync is the partner's side.
module compound_rr_arbiter
   import testbasic18_types::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  CompoundType      m_in0,
   input  logic             m_in0_sync,
   output logic             m_in0_notify,
   input  CompoundType      m_in1,
   input  logic             m_in1_sync,
   output logic             m_in1_notify,
   output CompoundType      b_out,
   input  logic             b_out_sync,
   output logic             b_out_notify,
   output logic             b_out_src,
   output logic [CNT_W-1:0] grant_cnt0,
   output logic [CNT_W-1:0] grant_cnt1
);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} section_t;

   section_t section, section_next;
   logic     ptr;
   logic     grant_valid;
   logic     grant_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         section <= IDLE;
      end else begin
         section <= section_next;
      end
   end

   // Grant is only offered from IDLE; with both requesters present, ptr breaks the tie.
   always_comb begin
      grant_valid  = 1'b0;
      grant_idx    = 1'b0;
      section_next = section;
      if (!rst) begin
         case (section)
            IDLE: begin
               if (m_in0_sync && m_in1_sync) begin
                  grant_valid = 1'b1;
                  grant_idx   = ptr;
               end else if (m_in0_sync) begin
                  grant_valid = 1'b1;
                  grant_idx   = 1'b0;
               end else if (m_in1_sync) begin
                  grant_valid = 1'b1;
                  grant_idx   = 1'b1;
               end
               if (grant_valid) begin
                  section_next = SEND;
               end
            end
            SEND: begin
               if (b_out_sync) begin
                  section_next = IDLE;
               end
            end
            default: section_next = IDLE;
         endcase
      end
   end

   assign m_in0_notify = grant_valid && (grant_idx == 1'b0);
   assign m_in1_notify = grant_valid && (grant_idx == 1'b1);

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr          <= 1'b0;
         b_out        <= '{mode: read, x: 32'sd0, y: 1'b0};
         b_out_notify <= 1'b0;
         b_out_src    <= 1'b0;
         grant_cnt0   <= '0;
         grant_cnt1   <= '0;
      end else if (grant_valid) begin
         b_out        <= grant_idx ? m_in1 : m_in0;
         b_out_src    <= grant_idx;
         b_out_notify <= 1'b1;
         ptr          <= ~grant_idx;
         if (grant_idx) begin
            grant_cnt1 <= grant_cnt1 + CNT_W'(1);
         end else begin
            grant_cnt0 <= grant_cnt0 + CNT_W'(1);
         end
      end else if (section == SEND && b_out_sync) begin
         // b_out keeps its last value after the handshake; only valid drops.
         b_out_notify <= 1'b0;
      end
   end

endmodule

// File: tb/tb_compound_rr_arbiter.sv
// Directed bench for compound_rr_arbiter: reset, single requester, contention,
// backpressure, reset in SEND and counter wrap, against hand-computed values.
module tb_compound_rr_arbiter;
   import testbasic18_types::*;

   localparam int CNT_W = 2;

   logic             clk;
   logic             rst;
   CompoundType      m_in0;
   logic             m_in0_sync;
   logic             m_in0_notify;
   CompoundType      m_in1;
   logic             m_in1_sync;
   logic             m_in1_notify;
   CompoundType      b_out;
   logic             b_out_sync;
   logic             b_out_notify;
   logic             b_out_src;
   logic [CNT_W-1:0] grant_cnt0;
   logic [CNT_W-1:0] grant_cnt1;

   int checks = 0;
   int errors = 0;

   compound_rr_arbiter #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .m_in0        (m_in0),
      .m_in0_sync   (m_in0_sync),
      .m_in0_notify (m_in0_notify),
      .m_in1        (m_in1),
      .m_in1_sync   (m_in1_sync),
      .m_in1_notify (m_in1_notify),
      .b_out        (b_out),
      .b_out_sync   (b_out_sync),
      .b_out_notify (b_out_notify),
      .b_out_src    (b_out_src),
      .grant_cnt0   (grant_cnt0),
      .grant_cnt1   (grant_cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow a further unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   CompoundType zero_c;
   CompoundType d_a;
   CompoundType d_b;
   CompoundType d_c;
   CompoundType d_0;
   CompoundType d_1;
   logic        exp_idx;

   initial begin
      zero_c     = '{mode: read, x: 32'sd0, y: 1'b0};
      rst        = 1'b1;
      m_in0      = '{mode: write, x: 32'sd11, y: 1'b1};
      m_in1      = '{mode: write, x: 32'sd22, y: 1'b1};
      m_in0_sync = 1'b1;
      m_in1_sync = 1'b1;
      b_out_sync = 1'b1;

      // Reset: notifies forced low while rst is high
      settle();
      check("rst_notify0", 64'(m_in0_notify), 64'd0);
      check("rst_notify1", 64'(m_in1_notify), 64'd0);
      tick();
      m_in0_sync = 1'b0;
      m_in1_sync = 1'b0;
      settle();
      check("rst_b_out", 64'(b_out), 64'(zero_c));
      check("rst_b_out_notify", 64'(b_out_notify), 64'd0);
      check("rst_b_out_src", 64'(b_out_src), 64'd0);
      check("rst_cnt0", 64'(grant_cnt0), 64'd0);
      check("rst_cnt1", 64'(grant_cnt1), 64'd0);
      rst = 1'b0;
      settle();

      // Single requester 1
      d_a        = '{mode: write, x: -32'sd5, y: 1'b1};
      m_in1      = d_a;
      m_in1_sync = 1'b1;
      b_out_sync = 1'b1;
      settle();
      check("single_notify1", 64'(m_in1_notify), 64'd1);
      check("single_notify0", 64'(m_in0_notify), 64'd0);
      tick();
      m_in1_sync = 1'b0;
      settle();
      check("single_b_out", 64'(b_out), 64'(d_a));
      check("single_src", 64'(b_out_src), 64'd1);
      check("single_valid", 64'(b_out_notify), 64'd1);
      check("single_send_notify1", 64'(m_in1_notify), 64'd0);
      check("single_cnt1", 64'(grant_cnt1), 64'd1);
      tick();
      check("single_done_valid", 64'(b_out_notify), 64'd0);
      check("single_hold_b_out", 64'(b_out), 64'(d_a));

      // Contention from reset: grants alternate starting at requester 0
      do_reset();
      m_in0_sync = 1'b1;
      m_in1_sync = 1'b1;
      b_out_sync = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d_0     = '{mode: read, x: 32'(i * 100 + 7), y: i[0]};
         d_1     = '{mode: write, x: -32'(i * 100 + 9), y: ~i[0]};
         m_in0   = d_0;
         m_in1   = d_1;
         exp_idx = i[0];
         settle();
         check($sformatf("cont%0d_notify0", i), 64'(m_in0_notify), 64'(!exp_idx));
         check($sformatf("cont%0d_notify1", i), 64'(m_in1_notify), 64'(exp_idx));
         tick();
         check($sformatf("cont%0d_src", i), 64'(b_out_src), 64'(exp_idx));
         check($sformatf("cont%0d_b_out", i), 64'(b_out), exp_idx ? 64'(d_1) : 64'(d_0));
         check($sformatf("cont%0d_send_notify0", i), 64'(m_in0_notify), 64'd0);
         check($sformatf("cont%0d_send_notify1", i), 64'(m_in1_notify), 64'd0);
         tick();
      end
      check("cont_cnt0", 64'(grant_cnt0), 64'd2);
      check("cont_cnt1", 64'(grant_cnt1), 64'd2);

      // Backpressure: requester 0 only, consumer stalls 5 cycles
      m_in1_sync = 1'b0;
      m_in0_sync = 1'b1;
      b_out_sync = 1'b0;
      d_b        = '{mode: write, x: 32'sh7fffffff, y: 1'b0};
      m_in0      = d_b;
      settle();
      check("bp_notify0", 64'(m_in0_notify), 64'd1);
      tick();
      m_in0 = '{mode: read, x: -32'sd1, y: 1'b1};
      for (int i = 0; i < 5; i++) begin
         settle();
         check($sformatf("bp%0d_b_out", i), 64'(b_out), 64'(d_b));
         check($sformatf("bp%0d_valid", i), 64'(b_out_notify), 64'd1);
         check($sformatf("bp%0d_notify0", i), 64'(m_in0_notify), 64'd0);
         check($sformatf("bp%0d_notify1", i), 64'(m_in1_notify), 64'd0);
         tick();
      end
      check("bp_cnt0", 64'(grant_cnt0), 64'd3);
      // Handshake and pending request on the same edge: only the handshake completes
      b_out_sync = 1'b1;
      settle();
      check("bp_release_notify0", 64'(m_in0_notify), 64'd0);
      tick();
      check("bp_release_valid", 64'(b_out_notify), 64'd0);
      d_c   = '{mode: read, x: -32'sd123456, y: 1'b1};
      m_in0 = d_c;
      settle();
      check("bp_next_notify0", 64'(m_in0_notify), 64'd1);
      tick();
      check("bp_next_b_out", 64'(b_out), 64'(d_c));
      check("bp_next_src", 64'(b_out_src), 64'd0);
      check("bp_cnt0_wrap", 64'(grant_cnt0), 64'd0);
      m_in0_sync = 1'b0;
      tick();

      // Reset in SEND: grant requester 0 so ptr moves to 1, then reset with consumer ready
      do_reset();
      m_in0_sync = 1'b1;
      tick();
      m_in0_sync = 1'b0;
      settle();
      check("mid_cnt0_before", 64'(grant_cnt0), 64'd1);
      rst        = 1'b1;
      b_out_sync = 1'b1;
      m_in0_sync = 1'b1;
      m_in1_sync = 1'b1;
      settle();
      check("mid_rst_notify0", 64'(m_in0_notify), 64'd0);
      check("mid_rst_notify1", 64'(m_in1_notify), 64'd0);
      tick();
      rst = 1'b0;
      settle();
      check("mid_valid", 64'(b_out_notify), 64'd0);
      check("mid_cnt0", 64'(grant_cnt0), 64'd0);
      check("mid_b_out", 64'(b_out), 64'(zero_c));
      check("mid_ptr_notify0", 64'(m_in0_notify), 64'd1);
      check("mid_ptr_notify1", 64'(m_in1_notify), 64'd0);
      m_in0_sync = 1'b0;
      m_in1_sync = 1'b0;

      // Counter wrap with CNT_W=2: five transfers from requester 0 leave 1
      do_reset();
      m_in0_sync = 1'b1;
      b_out_sync = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         tick();
      end
      m_in0_sync = 1'b0;
      settle();
      check("wrap_cnt0", 64'(grant_cnt0), 64'd1);
      check("wrap_cnt1", 64'(grant_cnt1), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/compound_rr_arbiter.md
Name: compound_rr_arbiter

Overview:
- Round-robin arbiter sharing one blocking CompoundType output port between two requesters, each with its own blocking input port.
- Sits in front of a CompoundType consumer with a single `b_out` style port, so two producers can drive it.
- Sequenced by a two-section controller: IDLE accepts a transaction, SEND holds it until the consumer takes it.
- Also tags the source of each forwarded transaction and counts grants per requester.

Parameters:
- CNT_W, 16, width of each per-requester grant counter (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- m_in0  input  CompoundType  requester 0 data (packed struct from testbasic18_types: mode {read,write}, x signed 32-bit, y bool).
- m_in0_sync  input  1  requester 0 has valid data.
- m_in0_notify  output  1  arbiter takes requester 0 data this cycle.
- m_in1  input  CompoundType  requester 1 data.
- m_in1_sync  input  1  requester 1 has valid data.
- m_in1_notify  output  1  arbiter takes requester 1 data this cycle.
- b_out  output  CompoundType  forwarded transaction.
- b_out_sync  input  1  consumer ready.
- b_out_notify  output  1  b_out valid.
- b_out_src  output  1  index of the requester whose data is on b_out.
- grant_cnt0  output  CNT_W  number of transfers accepted from requester 0.
- grant_cnt1  output  CNT_W  number of transfers accepted from requester 1.

Behaviour:
- Transfer rule: a transfer occurs on an edge where a port's sync and notify are both high.
- Sections: IDLE and SEND.
- Internal round-robin pointer `ptr` (1 bit) names the preferred requester.
- Combinational grant, IDLE only:
  - If both sync inputs are high, grant requester `ptr`.
  - If exactly one sync is high, grant that requester.
  - If neither is high, no grant.
- `m_inK_notify` = (section==IDLE) && grant==K. At most one notify is ever high. Both are low in SEND.
- IDLE with a grant to K, at the edge:
  - b_out <= m_inK; b_out_src <= K; b_out_notify <= 1.
  - ptr <= ~K.
  - grant_cntK <= grant_cntK+1, wrapping from all-ones to 0.
  - section <= SEND.
- IDLE with no grant: hold all state.
- SEND:
  - b_out, b_out_src and b_out_notify are held stable.
  - When b_out_sync=1 at the edge: b_out_notify <= 0 and section <= IDLE.
  - b_out retains its last value after the handshake.
- Latency and throughput:
  - Input accepted at edge N → b_out_notify high after edge N.
  - Earliest consumer handshake is at edge N+1.
  - Next input acceptance is at edge N+2, so maximum throughput is one transaction per two cycles.
- Data passes unmodified; mode, x and y are copied bit-exact.
- Reset (synchronous, rst=1 at an edge) sets:
  - section=IDLE, ptr=0.
  - b_out.mode=read, b_out.x=0, b_out.y=0.
  - b_out_notify=0, b_out_src=0, grant_cnt0=0, grant_cnt1=0.
- While rst=1, both m_in notifies are forced to 0.
- Reset mid-SEND discards the pending transaction; no handshake completes on the reset edge.
- A requester dropping sync while not granted has no effect.
- A sync asserted in SEND waits until IDLE, then competes normally.
- Simultaneous b_out_sync and new requests in SEND: only the output handshake completes; requests are evaluated in the following IDLE cycle.

Test Plan:
- Reset: assert rst one cycle → b_out={read,0,0}, b_out_notify=0, b_out_src=0, counters 0, both m_in notifies 0.
- Single requester:
  - Stimulus: m_in1={write,-5,1} with m_in1_sync=1; b_out_sync=1.
  - Response: m_in1_notify high in IDLE; next cycle b_out={write,-5,1}, b_out_src=1, b_out_notify=1; handshake completes; grant_cnt1=1, ptr=0.
- Contention:
  - Stimulus: both syncs held high for 8 cycles, b_out_sync=1, starting from reset.
  - Response: grants alternate 0,1,0,1; b_out_src sequence 0,1,0,1; grant_cnt0=2, grant_cnt1=2.
- Backpressure:
  - Stimulus: b_out_sync=0 for 5 cycles after a grant, with m_in0_sync=1.
  - Response: b_out stable, b_out_notify stays 1, both m_in notifies stay 0; after b_out_sync=1, return to IDLE and next grant follows.
- Reset mid-operation: rst=1 while in SEND with b_out_sync=1 → no transfer counted; b_out_notify=0 the next cycle; ptr=0.
- Counter wrap: with CNT_W=2, perform 5 transfers from requester 0 → grant_cnt0=1.
